// File: rtl/vga_ram_arb_pkg.sv
// Shared definitions for the frame-buffer RAM write-port arbiter.
//   arb_state_e : arbiter FSM encoding (ARB = no owner, BURST = owner locked)
//   ADDR_W      : width of requester / RAM write addresses
//   idx_w(n)    : width of an index selecting one of n requesters
package vga_ram_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int ADDR_W = 32;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/vga_ram_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector, one bit per requester
//   ptr  : requester with highest priority this cycle
//   any  : at least one request is present
//   idx  : first requesting index scanning ptr, ptr+1, ... mod N
module rr_pick
  import vga_ram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic                  any,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int IDX_W = idx_w(N);

  // Scan from the farthest offset down to offset 0 so that the candidate
  // closest to ptr is the last (and therefore winning) assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vga_ram_wr_arbiter.sv
// vga_ram_wr_arbiter: shares the single frame-buffer RAM write port among
// NUM_REQ requesters with round-robin arbitration and burst locking.
//
// Handshake: a beat from requester i transfers in the cycle where
// req_valid[i] && req_ready[i]; req_ready is combinational and never depends
// on the same requester's req_valid while a burst owner is locked.
//
// Ports
//   clk        single clock (RAM write clock is tied to it)
//   rst        synchronous, active-high reset
//   req_valid  per-requester beat valid
//   req_last   per-requester last-beat-of-burst flag
//   req_addr   packed addresses, requester i at [32*i +: 32]
//   req_data   packed data, requester i at [DATA_WIDTH*i +: DATA_WIDTH]
//   req_ready  per-requester ready
//   ram_we     RAM write enable (registered, one cycle after acceptance)
//   ram_w_addr RAM write address (holds last accepted beat)
//   ram_wd     RAM write data (holds last accepted beat)
//   oor_err    one-cycle pulse: accepted beat had addr >= LENGTH
//   busy       high while the FSM is in BURST (direct view of FSM state)
//   grant_id   current / most recent owner
//
// Optional feature macro: VGA_RAM_ARB_STATS_EN adds saturating statistics
// outputs grant_cnt (16 bits per requester) and oor_cnt.
module vga_ram_wr_arbiter
  import vga_ram_arb_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter longint LENGTH    = 65536,
  parameter int    NUM_REQ    = 2,
  parameter int    MAX_BURST  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_w_addr,
  output logic [DATA_WIDTH-1:0]         ram_wd,
  output logic                          oor_err,
  output logic                          busy,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id
`ifdef VGA_RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   oor_cnt
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W:0]   LEN_EXT   = (ADDR_W + 1)'(LENGTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam bit                SINGLE    = (MAX_BURST == 1);

  localparam logic [0:0] S_ARB   = ARB;
  localparam logic [0:0] S_BURST = BURST;

  logic [0:0]            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_idx;

  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      sel_next;
  logic                  grant_ok;
  logic                  accept;
  logic                  acc_last;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  in_range;
  logic                  burst_end;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // In ARB the picker chooses; in BURST the locked owner is always ready,
  // even with its valid low, so it can stall without losing the grant.
  always_comb begin
    sel      = grant_id;
    grant_ok = 1'b1;
    if (state == S_ARB) begin
      sel      = pick_idx;
      grant_ok = pick_any;
    end
    req_ready = '0;
    acc_last  = 1'b0;
    acc_addr  = '0;
    acc_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        req_ready[i] = grant_ok;
        acc_last     = req_last[i];
        acc_addr     = req_addr[ADDR_W*i +: ADDR_W];
        acc_data     = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign in_range  = {1'b0, acc_addr} < LEN_EXT;
  assign burst_end = acc_last || (beat_cnt == LAST_CNT);
  assign sel_next  = (sel == LAST_IDX) ? '0 : sel + 1'b1;
  assign busy      = (state == S_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ARB;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id   <= '0;
      ram_we     <= 1'b0;
      ram_w_addr <= '0;
      ram_wd     <= '0;
      oor_err    <= 1'b0;
    end else begin
      // Out-of-range beats are still consumed and latched; only the
      // write enable is suppressed.
      ram_we  <= accept && in_range;
      oor_err <= accept && !in_range;
      if (accept) begin
        ram_w_addr <= acc_addr;
        ram_wd     <= acc_data;
      end
      case (state)
        S_ARB: begin
          if (accept) begin
            grant_id <= sel;
            if (acc_last || SINGLE) begin
              rr_ptr <= sel_next;
            end else begin
              state    <= S_BURST;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        S_BURST: begin
          if (accept) begin
            // A forced exit at MAX_BURST returns the requester to
            // arbitration for whatever beats it still has.
            if (burst_end) begin
              state    <= S_ARB;
              rr_ptr   <= sel_next;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= S_ARB;
      endcase
    end
  end

`ifdef VGA_RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      oor_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && sel == IDX_W'(i) && grant_cnt[16*i +: 16] != 16'hFFFF)
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
      if (accept && !in_range && oor_cnt != 16'hFFFF)
        oor_cnt <= oor_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_ram_wr_arbiter.sv
// Directed bench for vga_ram_wr_arbiter (NUM_REQ=2, MAX_BURST=4).
module tb_vga_ram_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [63:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        ram_we;
  logic [31:0] ram_w_addr;
  logic [7:0]  ram_wd;
  logic        oor_err;
  logic        busy;
  logic [0:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_ram_wr_arbiter #(
    .DATA_WIDTH (8),
    .LENGTH     (65536),
    .NUM_REQ    (2),
    .MAX_BURST  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ram_we     (ram_we),
    .ram_w_addr (ram_w_addr),
    .ram_wd     (ram_wd),
    .oor_err    (oor_err),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic l,
                       input logic [31:0] a, input logic [7:0] d);
    req_valid[i]         = v;
    req_last[i]          = l;
    req_addr[32*i +: 32] = a;
    req_data[8*i +: 8]   = d;
  endtask

  task automatic idle();
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  // Writes observed one cycle after an accepted beat.
  task automatic check_wr(input string tag, input logic we, input logic [31:0] a,
                          input logic [7:0] d, input logic oor);
    check({tag, "_we"},   32'(ram_we),   32'(we));
    check({tag, "_addr"}, ram_w_addr,    a);
    check({tag, "_wd"},   32'(ram_wd),   32'(d));
    check({tag, "_oor"},  32'(oor_err),  32'(oor));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    // ---------------- reset state
    check_wr("rst", 1'b0, 32'h0, 8'h00, 1'b0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_grant", 32'(grant_id),  32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    tick();

    // ---------------- single beat from req0
    drive(0, 1'b1, 1'b1, 32'd5, 8'hA5);
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    idle();
    check_wr("single", 1'b1, 32'd5, 8'hA5, 1'b0);
    check("single_busy", 32'(busy), 32'h0);
    tick();
    check_wr("single_hold", 1'b0, 32'd5, 8'hA5, 1'b0);

    // ---------------- contention: rr_ptr is 1, so grants go 1,0,1,0
    drive(0, 1'b1, 1'b1, 32'h10, 8'h11);
    drive(1, 1'b1, 1'b1, 32'h20, 8'h22);
    for (int k = 0; k < 4; k++) begin
      logic [0:0] id;
      id = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      check("cont_ready", 32'(req_ready), (id == 1'b1) ? 32'h2 : 32'h1);
      tick();
      check_wr("cont", 1'b1, (id == 1'b1) ? 32'h20 : 32'h10,
               (id == 1'b1) ? 8'h22 : 8'h11, 1'b0);
      check("cont_grant", 32'(grant_id), 32'(id));
    end
    idle();
    tick();
    check("cont_idle_we", 32'(ram_we), 32'h0);

    // ---------------- burst lock: req1 4 beats, req0 waiting, stall on beat 3
    drive(0, 1'b1, 1'b1, 32'h40, 8'h44);
    for (int b = 1; b <= 4; b++) begin
      if (b == 3) begin
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00);
        #1;
        check("lock_stall_ready", 32'(req_ready), 32'h2);
        tick();
        check("lock_stall_we",   32'(ram_we), 32'h0);
        check("lock_stall_busy", 32'(busy),   32'h1);
      end
      drive(1, 1'b1, (b == 4), 32'h100 + 32'(b), 8'(b));
      #1;
      check("lock_ready", 32'(req_ready), 32'h2);
      tick();
      check_wr("lock", 1'b1, 32'h100 + 32'(b), 8'(b), 1'b0);
      check("lock_busy",  32'(busy),     (b < 4) ? 32'h1 : 32'h0);
      check("lock_grant", 32'(grant_id), 32'h1);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    check("after_lock_ready", 32'(req_ready), 32'h1);
    tick();
    idle();
    check_wr("after_lock", 1'b1, 32'h40, 8'h44, 1'b0);
    check("after_lock_grant", 32'(grant_id), 32'h0);

    // req1 single beat moves rr_ptr back to 0
    drive(1, 1'b1, 1'b1, 32'h50, 8'h55);
    tick();
    idle();
    check_wr("prep", 1'b1, 32'h50, 8'h55, 1'b0);

    // ---------------- forced exit at MAX_BURST=4: req0 6 beats, req1 waiting
    drive(1, 1'b1, 1'b1, 32'h300, 8'h33);
    for (int b = 1; b <= 4; b++) begin
      drive(0, 1'b1, 1'b0, 32'h200 + 32'(b), 8'h80 + 8'(b));
      #1;
      check("max_ready", 32'(req_ready), 32'h1);
      tick();
      check_wr("max", 1'b1, 32'h200 + 32'(b), 8'h80 + 8'(b), 1'b0);
      check("max_busy", 32'(busy), (b < 4) ? 32'h1 : 32'h0);
    end
    drive(0, 1'b1, 1'b0, 32'h205, 8'h85);
    #1;
    check("max_rearb_ready", 32'(req_ready), 32'h2);
    tick();
    check_wr("max_rearb", 1'b1, 32'h300, 8'h33, 1'b0);
    check("max_rearb_grant", 32'(grant_id), 32'h1);
    drive(1, 1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    check("max_b5_ready", 32'(req_ready), 32'h1);
    tick();
    check_wr("max_b5", 1'b1, 32'h205, 8'h85, 1'b0);
    check("max_b5_busy", 32'(busy), 32'h1);
    drive(0, 1'b1, 1'b1, 32'h206, 8'h86);
    tick();
    idle();
    check_wr("max_b6", 1'b1, 32'h206, 8'h86, 1'b0);
    check("max_b6_busy", 32'(busy), 32'h0);

    // ---------------- out-of-range and boundary addresses (rr_ptr is 1)
    drive(1, 1'b1, 1'b1, 32'd65536, 8'h77);
    #1;
    check("oor_ready", 32'(req_ready), 32'h2);
    tick();
    idle();
    check_wr("oor", 1'b0, 32'd65536, 8'h77, 1'b0 | 1'b1);
    tick();
    check("oor_pulse_end", 32'(oor_err), 32'h0);
    drive(0, 1'b1, 1'b1, 32'd65535, 8'h78);
    tick();
    idle();
    check_wr("edge_in", 1'b1, 32'd65535, 8'h78, 1'b0);
    drive(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'h79);
    tick();
    idle();
    check_wr("edge_max", 1'b0, 32'hFFFF_FFFF, 8'h79, 1'b1);

    // ---------------- reset mid-burst (rr_ptr 1 after req0 beat)
    drive(0, 1'b1, 1'b1, 32'h60, 8'h66);
    tick();
    idle();
    for (int b = 1; b <= 2; b++) begin
      drive(1, 1'b1, 1'b0, 32'h400 + 32'(b), 8'(b));
      tick();
    end
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("rst_mid_we",    32'(ram_we),   32'h0);
    check("rst_mid_busy",  32'(busy),     32'h0);
    check("rst_mid_grant", 32'(grant_id), 32'h0);
    drive(0, 1'b1, 1'b1, 32'h70, 8'h01);
    drive(1, 1'b1, 1'b1, 32'h71, 8'h02);
    #1;
    check("rst_rr_ready", 32'(req_ready), 32'h1);
    tick();
    idle();
    check_wr("rst_rr", 1'b1, 32'h70, 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
